// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard driving decode stall and EX forwarding selects.
module hazard_scoreboard #(
    parameter int NUM_RS  = 2,
    parameter int REG_AW  = 5,
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [REG_AW-1:0]        issue_rd,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic                     flush,
    input  logic [NUM_RS*REG_AW-1:0] rs_dec,
    input  logic [NUM_RS-1:0]        rs_used,
    input  logic [NUM_RS*REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0]        rd_mem,
    input  logic                     mem_we,
    input  logic [REG_AW-1:0]        rd_wb,
    input  logic                     wb_we,
    output logic                     stall,
    output logic [NUM_RS*2-1:0]      sel_f,
    output logic [2**REG_AW-1:0]     busy_vec
);
    localparam int NREG = 2 ** REG_AW;

    logic [LAT_W-1:0] cnt [NREG];
    logic [LAT_W-1:0] lat_eff;
    logic [LAT_W-1:0] lat_m1;
    logic             raw;
    logic             waw;
    logic             fire;

    always_comb begin
        lat_eff = (issue_lat == '0) ? LAT_W'(1) :
                  (issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;
        lat_m1 = lat_eff - LAT_W'(1);
        raw = 1'b0;
        for (int i = 0; i < NUM_RS; i++)
            raw = raw | (rs_used[i] && rs_dec[i*REG_AW +: REG_AW] != '0 &&
                         cnt[rs_dec[i*REG_AW +: REG_AW]] != '0);
        // a younger write must not retire before an older, slower one to the same rd
        waw = issue_we && issue_rd != '0 && cnt[issue_rd] > lat_m1;
        stall = issue_valid && !flush && (raw || waw);
        fire = issue_valid && !flush && !stall && issue_we && issue_rd != '0;
    end

    always_comb begin
        sel_f = '0;
        for (int i = 0; i < NUM_RS; i++)
            sel_f[i*2 +: 2] =
                (rs_ex[i*REG_AW +: REG_AW] != '0 && mem_we && rd_mem == rs_ex[i*REG_AW +: REG_AW]) ? 2'b01 :
                (rs_ex[i*REG_AW +: REG_AW] != '0 && wb_we && rd_wb == rs_ex[i*REG_AW +: REG_AW]) ? 2'b10 : 2'b00;
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++)
            busy_vec[r] = cnt[r] != '0;
    end

    // entry 0 is never targeted by fire and starts at zero, so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= (fire && issue_rd == REG_AW'(r)) ? lat_m1 :
                          (cnt[r] != '0) ? cnt[r] - LAT_W'(1) : cnt[r];
        end
    end
endmodule
